condlogic_mctx: RTL and testbench

- Multi-context conditional-execution unit for the multicycle ARM datapath; successor to the single-context condition logic.
- Holds one NZCV flag register per hardware context (NCTX) and evaluates the 4-bit condition field against the issuing context's flags.
- Defers flag writes from the execute state to the ALU write-back state, forwarding pending flags to later condition checks in the same context.
- Gates PCWrite, RegWrite and MemWrite with a registered condition result.

---
 rtl/cond_pkg.sv | 32 +++
 rtl/cond_eval.sv | 40 ++++
 rtl/condlogic_mctx.sv | 139 +++++++++++++
 tb/tb_condlogic_mctx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the ARM condition-logic blocks: condition codes,
// NZCV bit positions and the two flag-write groups.
package cond_pkg;

   typedef logic [3:0] flags_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] GRP_NZ = 2'b10;
   localparam logic [1:0] GRP_CV = 2'b01;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM condition evaluator: {Cond, NZCV} -> CondEx.
module cond_eval
   import cond_pkg::*;
#(
   parameter int NV_ALWAYS = 1
) (
   input  logic [3:0] Cond,
   input  flags_t     Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   always_comb begin
      n = Flags[FLAG_N];
      z = Flags[FLAG_Z];
      c = Flags[FLAG_C];
      v = Flags[FLAG_V];
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = (NV_ALWAYS != 0);
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/condlogic_mctx.sv
// Multi-context condition logic: per-context NZCV bank, one deferred flag
// write with forwarding, and registered gating of PC/Reg/Mem writes.
module condlogic_mctx
   import cond_pkg::*;
#(
   parameter  int NCTX      = 2,
   parameter  int NV_ALWAYS = 1,
   localparam int CTXW      = (NCTX > 1) ? $clog2(NCTX) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CTXW-1:0] Ctx,
   input  logic [3:0]      Cond,
   input  logic [3:0]      ALUFlags,
   input  logic [1:0]      FlagW,
   input  logic            CondCapture,
   input  logic            FlagCommit,
   input  logic            PCS,
   input  logic            NextPC,
   input  logic            RegW,
   input  logic            MemW,
   output logic            PCWrite,
   output logic            RegWrite,
   output logic            MemWrite,
   output logic            CondExQ,
   output logic            FlagPending,
   output logic [3:0]      CtxFlags
);

   flags_t          bank_flags [NCTX];
   flags_t          bank_rd;
   flags_t          eff_flags;
   logic            ctx_ok;
   logic            cond_ex;
   logic            commit;
   logic [1:0]      pend_we;

   logic            pend_valid_q, pend_valid_d;
   logic [CTXW-1:0] pend_ctx_q,   pend_ctx_d;
   logic [1:0]      pend_mask_q,  pend_mask_d;
   flags_t          pend_data_q,  pend_data_d;
   logic            cond_exq_q,   cond_exq_d;

   assign ctx_ok = (int'(Ctx) < NCTX);
   // Any capture retires the outstanding write so it can never be overwritten.
   assign commit = pend_valid_q & (FlagCommit | CondCapture);

   for (genvar gi = 0; gi < NCTX; gi++) begin : g_bank
      flags_t entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (commit && pend_ctx_q == CTXW'(gi)) begin
            if ((pend_mask_q & GRP_NZ) != 2'b00) begin
               entry_d[FLAG_N] = pend_data_q[FLAG_N];
               entry_d[FLAG_Z] = pend_data_q[FLAG_Z];
            end
            if ((pend_mask_q & GRP_CV) != 2'b00) begin
               entry_d[FLAG_C] = pend_data_q[FLAG_C];
               entry_d[FLAG_V] = pend_data_q[FLAG_V];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) entry_q <= '0;
         else       entry_q <= entry_d;
      end

      assign bank_flags[gi] = entry_q;
   end

   always_comb begin
      bank_rd = '0;
      for (int i = 0; i < NCTX; i++) begin
         if (Ctx == CTXW'(i)) bank_rd = bank_flags[i];
      end
   end

   always_comb begin
      eff_flags = bank_rd;
      if (pend_valid_q && ctx_ok && pend_ctx_q == Ctx) begin
         if ((pend_mask_q & GRP_NZ) != 2'b00) begin
            eff_flags[FLAG_N] = pend_data_q[FLAG_N];
            eff_flags[FLAG_Z] = pend_data_q[FLAG_Z];
         end
         if ((pend_mask_q & GRP_CV) != 2'b00) begin
            eff_flags[FLAG_C] = pend_data_q[FLAG_C];
            eff_flags[FLAG_V] = pend_data_q[FLAG_V];
         end
      end
   end

   cond_eval #(.NV_ALWAYS(NV_ALWAYS)) u_eval (
      .Cond   (Cond),
      .Flags  (eff_flags),
      .CondEx (cond_ex)
   );

   always_comb begin
      pend_we      = FlagW & {2{cond_ex & ctx_ok}};
      pend_valid_d = pend_valid_q & ~commit;
      pend_ctx_d   = pend_ctx_q;
      pend_mask_d  = pend_mask_q;
      pend_data_d  = pend_data_q;
      cond_exq_d   = cond_exq_q;
      if (CondCapture) begin
         cond_exq_d   = cond_ex;
         pend_valid_d = |pend_we;
         pend_mask_d  = pend_we;
         pend_data_d  = ALUFlags;
         pend_ctx_d   = Ctx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_ctx_q   <= '0;
         pend_mask_q  <= '0;
         pend_data_q  <= '0;
         cond_exq_q   <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_ctx_q   <= pend_ctx_d;
         pend_mask_q  <= pend_mask_d;
         pend_data_q  <= pend_data_d;
         cond_exq_q   <= cond_exq_d;
      end
   end

   assign CondExQ     = cond_exq_q;
   assign FlagPending = pend_valid_q;
   assign CtxFlags    = eff_flags;
   assign RegWrite    = RegW & cond_exq_q;
   assign MemWrite    = MemW & cond_exq_q;
   assign PCWrite     = (PCS & cond_exq_q) | NextPC;

endmodule

// File: tb/tb_condlogic_mctx.sv
// Directed bench for condlogic_mctx, built with three contexts so that an
// out-of-range context index is reachable.
module tb_condlogic_mctx;

   localparam int NCTX = 3;
   localparam int CTXW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [CTXW-1:0] Ctx;
   logic [3:0]      Cond;
   logic [3:0]      ALUFlags;
   logic [1:0]      FlagW;
   logic            CondCapture, FlagCommit;
   logic            PCS, NextPC, RegW, MemW;
   logic            PCWrite, RegWrite, MemWrite, CondExQ, FlagPending;
   logic [3:0]      CtxFlags;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   condlogic_mctx #(.NCTX(NCTX), .NV_ALWAYS(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .Ctx         (Ctx),
      .Cond        (Cond),
      .ALUFlags    (ALUFlags),
      .FlagW       (FlagW),
      .CondCapture (CondCapture),
      .FlagCommit  (FlagCommit),
      .PCS         (PCS),
      .NextPC      (NextPC),
      .RegW        (RegW),
      .MemW        (MemW),
      .PCWrite     (PCWrite),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .CondExQ     (CondExQ),
      .FlagPending (FlagPending),
      .CtxFlags    (CtxFlags)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [CTXW-1:0] c, input logic [3:0] cd,
                          input logic [1:0] fw, input logic [3:0] alu);
      Ctx = c; Cond = cd; FlagW = fw; ALUFlags = alu; CondCapture = 1'b1;
      tick();
      CondCapture = 1'b0; FlagW = 2'b00;
      $display("capture ctx=%0d cond=%h flagw=%b alu=%b -> condexq=%b pend=%b flags=%b",
               c, cd, fw, alu, CondExQ, FlagPending, CtxFlags);
   endtask

   task automatic commit();
      FlagCommit = 1'b1;
      tick();
      FlagCommit = 1'b0;
      $display("commit -> pend=%b flags=%b", FlagPending, CtxFlags);
   endtask

   task automatic test_reset();
      reset = 1'b1; Ctx = '0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      CondCapture = 1'b0; FlagCommit = 1'b0; PCS = 1'b0; NextPC = 1'b1; RegW = 1'b0; MemW = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (PCWrite !== 1'b1) $display("FAIL rst_pcwrite got=%b exp=1", PCWrite); else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL rst_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
      total_cnt++; if (MemWrite !== 1'b0) $display("FAIL rst_memwrite got=%b exp=0", MemWrite); else pass_cnt++;
      total_cnt++; if (CondExQ !== 1'b0) $display("FAIL rst_condexq got=%b exp=0", CondExQ); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b0000) $display("FAIL rst_ctxflags got=%b exp=0000", CtxFlags); else pass_cnt++;
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL rst_pending got=%b exp=0", FlagPending); else pass_cnt++;
      NextPC = 1'b0; PCS = 1'b1;
      #1;
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL rst_pcs_gated got=%b exp=0", PCWrite); else pass_cnt++;
      PCS = 1'b0;
   endtask

   task automatic test_capture_commit();
      Ctx = 2'd0; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100; CondCapture = 1'b1;
      #1;
      total_cnt++; if (CtxFlags !== 4'b0000) $display("FAIL cc_pre_flags got=%b exp=0000", CtxFlags); else pass_cnt++;
      tick();
      CondCapture = 1'b0; FlagW = 2'b00;
      total_cnt++; if (FlagPending !== 1'b1) $display("FAIL cc_pending got=%b exp=1", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b0100) $display("FAIL cc_fwd_flags got=%b exp=0100", CtxFlags); else pass_cnt++;
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL cc_condexq_al got=%b exp=1", CondExQ); else pass_cnt++;
      commit();
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL cc_pending_clr got=%b exp=0", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b0100) $display("FAIL cc_bank0 got=%b exp=0100", CtxFlags); else pass_cnt++;
      RegW = 1'b1; PCS = 1'b1;
      capture(2'd0, 4'h0, 2'b00, 4'b0000);
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL cc_eq_condexq got=%b exp=1", CondExQ); else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b1) $display("FAIL cc_eq_regwrite got=%b exp=1", RegWrite); else pass_cnt++;
      total_cnt++; if (PCWrite !== 1'b1) $display("FAIL cc_eq_pcwrite got=%b exp=1", PCWrite); else pass_cnt++;
      capture(2'd0, 4'h1, 2'b00, 4'b0000);
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL cc_ne_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL cc_ne_pcwrite got=%b exp=0", PCWrite); else pass_cnt++;
      RegW = 1'b0; PCS = 1'b0;
   endtask

   task automatic test_isolation();
      MemW = 1'b1;
      capture(2'd1, 4'h0, 2'b00, 4'b0000);
      total_cnt++; if (CondExQ !== 1'b0) $display("FAIL iso_condexq got=%b exp=0", CondExQ); else pass_cnt++;
      total_cnt++; if (MemWrite !== 1'b0) $display("FAIL iso_memwrite got=%b exp=0", MemWrite); else pass_cnt++;
      Ctx = 2'd0;
      #1;
      total_cnt++; if (CtxFlags !== 4'b0100) $display("FAIL iso_bank0 got=%b exp=0100", CtxFlags); else pass_cnt++;
      capture(2'd0, 4'h0, 2'b00, 4'b0000);
      total_cnt++; if (MemWrite !== 1'b1) $display("FAIL iso_memwrite_ctx0 got=%b exp=1", MemWrite); else pass_cnt++;
      MemW = 1'b0;
   endtask

   task automatic test_forwarding();
      capture(2'd1, 4'hE, 2'b10, 4'b1000);
      total_cnt++; if (FlagPending !== 1'b1) $display("FAIL fwd_pending got=%b exp=1", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b1000) $display("FAIL fwd_ctx1 got=%b exp=1000", CtxFlags); else pass_cnt++;
      Ctx = 2'd0;
      #1;
      total_cnt++; if (CtxFlags !== 4'b0100) $display("FAIL fwd_other_ctx got=%b exp=0100", CtxFlags); else pass_cnt++;
      capture(2'd1, 4'h4, 2'b00, 4'b0000);
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL fwd_mi got=%b exp=1", CondExQ); else pass_cnt++;
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL fwd_implicit_pend got=%b exp=0", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b1000) $display("FAIL fwd_bank1 got=%b exp=1000", CtxFlags); else pass_cnt++;
      // CV-only write merges with the committed NZ of the same context
      capture(2'd1, 4'hE, 2'b01, 4'b0111);
      total_cnt++; if (CtxFlags !== 4'b1011) $display("FAIL fwd_cv_merge got=%b exp=1011", CtxFlags); else pass_cnt++;
      commit();
      total_cnt++; if (CtxFlags !== 4'b1011) $display("FAIL fwd_cv_bank got=%b exp=1011", CtxFlags); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      capture(2'd0, 4'hE, 2'b10, 4'b1000);
      Ctx = 2'd0; Cond = 4'h4; FlagW = 2'b01; ALUFlags = 4'b0011;
      CondCapture = 1'b1; FlagCommit = 1'b1;
      tick();
      CondCapture = 1'b0; FlagCommit = 1'b0; FlagW = 2'b00;
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL b2b_condexq got=%b exp=1", CondExQ); else pass_cnt++;
      total_cnt++; if (FlagPending !== 1'b1) $display("FAIL b2b_pending got=%b exp=1", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b1011) $display("FAIL b2b_fwd got=%b exp=1011", CtxFlags); else pass_cnt++;
      commit();
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL b2b_pend_clr got=%b exp=0", FlagPending); else pass_cnt++;
      total_cnt++; if (CtxFlags !== 4'b1011) $display("FAIL b2b_bank got=%b exp=1011", CtxFlags); else pass_cnt++;
   endtask

   task automatic test_failed_cond();
      capture(2'd0, 4'hE, 2'b10, 4'b0100);
      commit();
      total_cnt++; if (CtxFlags !== 4'b0111) $display("FAIL fc_setup got=%b exp=0111", CtxFlags); else pass_cnt++;
      capture(2'd0, 4'h1, 2'b11, 4'b0000);
      total_cnt++; if (CondExQ !== 1'b0) $display("FAIL fc_condexq got=%b exp=0", CondExQ); else pass_cnt++;
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL fc_pending got=%b exp=0", FlagPending); else pass_cnt++;
      commit();
      total_cnt++; if (CtxFlags !== 4'b0111) $display("FAIL fc_bank got=%b exp=0111", CtxFlags); else pass_cnt++;
   endtask

   task automatic test_cond_codes();
      logic [3:0]  flag_set [3];
      logic [15:0] exp_tab  [3];
      logic [15:0] row;
      flag_set[0] = 4'b1001; exp_tab[0] = 16'hD65A;
      flag_set[1] = 4'b0110; exp_tab[1] = 16'hE6A5;
      flag_set[2] = 4'b0010; exp_tab[2] = 16'hD5A6;
      for (int f = 0; f < 3; f++) begin
         capture(2'd2, 4'hE, 2'b11, flag_set[f]);
         commit();
         row = exp_tab[f];
         for (int c = 0; c < 16; c++) begin
            capture(2'd2, 4'(c), 2'b00, 4'b0000);
            total_cnt++;
            if (CondExQ !== row[c])
               $display("FAIL cond_code flags=%b cond=%h got=%b exp=%b", flag_set[f], c, CondExQ, row[c]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_bad_ctx();
      Ctx = 2'd3;
      #1;
      total_cnt++; if (CtxFlags !== 4'b0000) $display("FAIL bad_flags got=%b exp=0000", CtxFlags); else pass_cnt++;
      capture(2'd3, 4'hE, 2'b11, 4'b1111);
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL bad_pending got=%b exp=0", FlagPending); else pass_cnt++;
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL bad_al got=%b exp=1", CondExQ); else pass_cnt++;
      capture(2'd3, 4'h1, 2'b00, 4'b0000);
      total_cnt++; if (CondExQ !== 1'b1) $display("FAIL bad_ne got=%b exp=1", CondExQ); else pass_cnt++;
      Ctx = 2'd2;
      #1;
      total_cnt++; if (CtxFlags !== 4'b0010) $display("FAIL bad_ctx2_kept got=%b exp=0010", CtxFlags); else pass_cnt++;
   endtask

   task automatic test_reset_pending();
      capture(2'd1, 4'hE, 2'b11, 4'b1111);
      total_cnt++; if (FlagPending !== 1'b1) $display("FAIL rp_pending_set got=%b exp=1", FlagPending); else pass_cnt++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      $display("reset -> pend=%b condexq=%b", FlagPending, CondExQ);
      total_cnt++; if (FlagPending !== 1'b0) $display("FAIL rp_pending_clr got=%b exp=0", FlagPending); else pass_cnt++;
      total_cnt++; if (CondExQ !== 1'b0) $display("FAIL rp_condexq got=%b exp=0", CondExQ); else pass_cnt++;
      for (int c = 0; c < NCTX; c++) begin
         Ctx = CTXW'(c);
         #1;
         total_cnt++;
         if (CtxFlags !== 4'b0000) $display("FAIL rp_bank ctx=%0d got=%b exp=0000", c, CtxFlags);
         else pass_cnt++;
      end
      Ctx = 2'd1;
      commit();
      total_cnt++; if (CtxFlags !== 4'b0000) $display("FAIL rp_no_commit got=%b exp=0000", CtxFlags); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_capture_commit();
      test_isolation();
      test_forwarding();
      test_back_to_back();
      test_failed_cond();
      test_cond_codes();
      test_bad_ctx();
      test_reset_pending();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
